// File: rtl/cdc_hs_pkg.sv
// Shared types for the four-phase req/ack clock-domain-crossing handshake.
// Used by the source-side transmitter and the destination-side receiver.
package cdc_hs_pkg;

  // Handshake phase as seen by the source side.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ_HI      = 2'd1,
    ACK_WAIT_LO = 2'd2
  } hs_state_t;

  // Width needed to hold 0..max_val. Never returns zero, so a disabled
  // timeout (max_val == 0) still gets a legal one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for bringing asynchronous levels into i_clk.
// Ports:
//   i_clk      destination clock
//   i_reset_n  asynchronous active-low reset, clears every stage
//   i_data     asynchronous input bits
//   o_data     i_data delayed by NUM_FFS flops
module synchronizer #(
  parameter int unsigned LOGIC_SIZE = 1,
  parameter int unsigned NUM_FFS    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [LOGIC_SIZE-1:0] i_data,
  output logic [LOGIC_SIZE-1:0] o_data
);

  localparam int unsigned CHAIN_W = NUM_FFS * LOGIC_SIZE;

  logic [CHAIN_W-1:0] chain_q;

  // Shift chain; the newest sample enters at the low end.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[CHAIN_W-LOGIC_SIZE-1:0], i_data};
    end
  end

  assign o_data = chain_q[CHAIN_W-1 -: LOGIC_SIZE];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-side half of a four-phase req/ack CDC handshake. Takes one
// AXI-Stream beat at a time, holds it on o_data with o_req raised, and waits
// for the destination's acknowledge to rise and fall again before taking the
// next beat.
// Ports:
//   i_clk, i_reset_n      source clock, asynchronous active-low reset
//   i_s_axis_tdata/tvalid AXI-Stream beat in
//   o_s_axis_tready       ready, only in IDLE with synchronized ack low
//   o_data, o_req         registered crossing data and request level
//   i_ack                 destination acknowledge, asynchronous to i_clk
//   o_busy                handshake in progress
//   o_timeout             sticky: a waiting phase lasted TIMEOUT_CYCLES
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned NUM_FFS        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_s_axis_tdata,
  input  logic              i_s_axis_tvalid,
  output logic              o_s_axis_tready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_req,
  input  logic              i_ack,
  output logic              o_busy,
  output logic              o_timeout
);

  localparam int unsigned      CNT_W      = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  hs_state_t        state_q;
  hs_state_t        state_d;
  logic             ack_s;
  logic             accept;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  // Bring the destination acknowledge into this clock domain.
  synchronizer #(
    .LOGIC_SIZE (1),
    .NUM_FFS    (NUM_FFS)
  ) u_ack_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_data    (i_ack),
    .o_data    (ack_s)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. An ack rising outside REQ_HI is a receiver glitch and is
  // ignored here; in IDLE it only holds off tready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (accept) state_d = REQ_HI;
      REQ_HI:      if (ack_s)  state_d = ACK_WAIT_LO;
      ACK_WAIT_LO: if (!ack_s) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Combinational outputs and counter next value; no path from tvalid.
  always_comb begin
    o_s_axis_tready = (state_q == IDLE) && !ack_s;
    o_busy          = (state_q != IDLE);
    wait_cnt_d      = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (o_busy && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  assign accept = i_s_axis_tvalid && o_s_axis_tready;

  // Crossing data only loads on acceptance, so it is frozen for the whole
  // handshake including the ack-low wait.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data <= '0;
      o_req  <= 1'b0;
    end else if (accept) begin
      o_data <= i_s_axis_tdata;
      o_req  <= 1'b1;
    end else if ((state_q == REQ_HI) && ack_s) begin
      o_req  <= 1'b0;
    end
  end

  // Wait counter and sticky timeout; the handshake itself is never aborted.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_cnt_q <= '0;
      o_timeout  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (TIMEOUT_EN && (wait_cnt_d == CNT_MAX)) begin
        o_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: a behavioural destination receiver drives
// i_ack with programmable delays and records what it captures; a source
// driver records what was accepted; the two lists must match in order.
module tb_cdc_handshake_tx;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NUM_FFS = 2;
  localparam int unsigned TO_CYC  = 16;
  localparam int          CLK_P   = 10;

  logic              i_clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic [DATA_W-1:0] i_s_axis_tdata = '0;
  logic              i_s_axis_tvalid = 1'b0;
  logic              o_s_axis_tready;
  logic [DATA_W-1:0] o_data;
  logic              o_req;
  logic              i_ack = 1'b0;
  logic              o_busy;
  logic              o_timeout;

  int compared = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] rx_q[$];

  // Receiver control: delays are counted in source cycles.
  bit   rx_manual = 1'b0;
  logic rx_manual_ack = 1'b0;
  bit   rx_rand = 1'b0;
  int   cur_r = 2;
  int   cur_f = 2;
  int   rx_cnt = 0;

  time  acc_t = 0;
  int   stab_err = 0;

  cdc_handshake_tx #(
    .DATA_W         (DATA_W),
    .NUM_FFS        (NUM_FFS),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_s_axis_tdata  (i_s_axis_tdata),
    .i_s_axis_tvalid (i_s_axis_tvalid),
    .o_s_axis_tready (o_s_axis_tready),
    .o_data          (o_data),
    .o_req           (o_req),
    .i_ack           (i_ack),
    .o_busy          (o_busy),
    .o_timeout       (o_timeout)
  );

  initial forever #(CLK_P/2) i_clk = ~i_clk;

  // Destination receiver: raises ack cur_r cycles after seeing req, captures
  // the data then, drops ack cur_f cycles after req falls.
  initial begin
    forever begin
      @(negedge i_clk);
      if (rx_manual) begin
        i_ack  = rx_manual_ack;
        rx_cnt = 0;
      end else if (!i_reset_n) begin
        i_ack  = 1'b0;
        rx_cnt = 0;
      end else if (!i_ack && o_req) begin
        rx_cnt++;
        if (rx_cnt >= cur_r) begin
          i_ack  = 1'b1;
          rx_cnt = 0;
          rx_q.push_back(o_data);
          if (rx_rand) cur_f = $urandom_range(1, 20);
        end
      end else if (i_ack && !o_req) begin
        rx_cnt++;
        if (rx_cnt >= cur_f) begin
          i_ack  = 1'b0;
          rx_cnt = 0;
          if (rx_rand) cur_r = $urandom_range(1, 20);
        end
      end else begin
        rx_cnt = 0;
      end
    end
  end

  // o_data may only change on the edge that leaves IDLE.
  initial begin
    logic              prev_ok;
    logic              prev_busy;
    logic [DATA_W-1:0] prev_data;
    prev_ok   = 1'b0;
    prev_busy = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge i_clk);
      if (i_reset_n && prev_ok && prev_busy && (o_data !== prev_data)) stab_err++;
      prev_ok   = i_reset_n;
      prev_busy = o_busy;
      prev_data = o_data;
    end
  end

  // Hard stop if something hangs.
  initial begin
    #(CLK_P * 90000);
    $display("FAIL watchdog: simulation did not finish within 90000 cycles");
    $fatal(1);
  end

  // Present a beat and wait for acceptance; returns just after the accepting edge.
  task automatic send_beat(input logic [DATA_W-1:0] d, input int budget, output bit ok);
    @(negedge i_clk);
    i_s_axis_tvalid = 1'b1;
    i_s_axis_tdata  = d;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_s_axis_tready) begin
        exp_q.push_back(d);
        @(posedge i_clk);
        acc_t = $time;
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL accept: beat %h not accepted, got tready=%b within %0d cycles, need 1",
               d, o_s_axis_tready, budget);
      i_s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (!o_busy && !i_ack) begin
        done = 1'b1;
        break;
      end
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL %s_idle: busy=%b ack=%b after %0d cycles, need both 0", tag, o_busy, i_ack, budget);
    end
  endtask

  task automatic check_queues(input string tag);
    compared++;
    if (rx_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL %s_count: received %0d beats, sent %0d", tag, rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        compared++;
        if (rx_q[i] !== exp_q[i]) begin
          mismatched++;
          $display("FAIL %s_data[%0d]: got %h need %h", tag, i, rx_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_reset();
    bit got;
    rx_manual = 1'b1;
    rx_manual_ack = 1'b1;
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clk);
    compared += 4;
    if (o_req !== 1'b0)     begin mismatched++; $display("FAIL rst_req: got %b need 0", o_req); end
    if (o_data !== '0)      begin mismatched++; $display("FAIL rst_data: got %h need 00", o_data); end
    if (o_timeout !== 1'b0) begin mismatched++; $display("FAIL rst_timeout: got %b need 0", o_timeout); end
    if (o_busy !== 1'b0)    begin mismatched++; $display("FAIL rst_busy: got %b need 0", o_busy); end
    rx_manual_ack = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    got = 1'b0;
    for (int k = 0; k < int'(NUM_FFS); k++) begin
      @(negedge i_clk);
      if (o_s_axis_tready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL rst_tready: got %b need 1 within %0d cycles", o_s_axis_tready, NUM_FFS);
    end
    rx_manual = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    int req_fall;
    int idle_at;
    int data_err;
    cur_r = 2;
    cur_f = 2;
    req_fall = cur_r + int'(NUM_FFS);
    idle_at  = cur_r + cur_f + 2 * int'(NUM_FFS);
    data_err = 0;
    send_beat(8'hA5, 10, ok);
    if (ok) begin
      for (int k = 0; k <= idle_at; k++) begin
        @(negedge i_clk);
        if (k == 0) i_s_axis_tvalid = 1'b0;
        if (o_data !== 8'hA5) data_err++;
        if (k == 0 || k == req_fall - 1) begin
          compared++;
          if (o_req !== 1'b1) begin mismatched++; $display("FAIL single_req_hi@%0d: got %b need 1", k, o_req); end
        end
        if (k == req_fall) begin
          compared++;
          if (o_req !== 1'b0) begin mismatched++; $display("FAIL single_req_lo@%0d: got %b need 0", k, o_req); end
        end
        if (k == idle_at - 1) begin
          compared++;
          if (o_busy !== 1'b1) begin mismatched++; $display("FAIL single_busy@%0d: got %b need 1", k, o_busy); end
        end
        if (k == idle_at) begin
          compared += 2;
          if (o_busy !== 1'b0) begin mismatched++; $display("FAIL single_idle@%0d: got %b need 0", k, o_busy); end
          if (o_s_axis_tready !== 1'b1) begin mismatched++; $display("FAIL single_tready@%0d: got %b need 1", k, o_s_axis_tready); end
        end
      end
      compared += 2;
      if (data_err != 0) begin mismatched++; $display("FAIL single_hold: o_data left A5 in %0d cycles, need 0", data_err); end
      if (o_timeout !== 1'b0) begin mismatched++; $display("FAIL single_timeout: got %b need 0", o_timeout); end
    end
    wait_idle(40, "single");
    check_queues("single");
  endtask

  task automatic test_back_to_back();
    bit  ok;
    time prev_t;
    time exp_period;
    cur_r = 1;
    cur_f = 2;
    // ack seen NUM_FFS after it rises, req falls one edge later; same on the fall.
    exp_period = time'((cur_r + cur_f + 2 * int'(NUM_FFS) + 1) * CLK_P);
    prev_t = 0;
    for (int i = 0; i < 16; i++) begin
      send_beat(DATA_W'(i), 40, ok);
      if (ok && i > 0) begin
        compared++;
        if ((acc_t - prev_t) !== exp_period) begin
          mismatched++;
          $display("FAIL b2b_period[%0d]: got %0t need %0t", i, acc_t - prev_t, exp_period);
        end
      end
      prev_t = acc_t;
    end
    @(negedge i_clk);
    i_s_axis_tvalid = 1'b0;
    wait_idle(40, "b2b");
    check_queues("b2b");
  endtask

  task automatic test_timeout();
    bit ok;
    rx_manual = 1'b1;
    rx_manual_ack = 1'b0;
    send_beat(8'h3C, 10, ok);
    if (ok) begin
      @(negedge i_clk);
      i_s_axis_tvalid = 1'b0;
      repeat (int'(TO_CYC) - 1) @(negedge i_clk);
      compared += 2;
      if (o_timeout !== 1'b0) begin mismatched++; $display("FAIL to_early: got %b need 0", o_timeout); end
      if (o_req !== 1'b1)     begin mismatched++; $display("FAIL to_req_pre: got %b need 1", o_req); end
      @(negedge i_clk);
      compared += 2;
      if (o_timeout !== 1'b1) begin mismatched++; $display("FAIL to_set: got %b need 1", o_timeout); end
      if (o_req !== 1'b1)     begin mismatched++; $display("FAIL to_req: got %b need 1", o_req); end
      repeat (10) @(negedge i_clk);
      compared++;
      if (o_req !== 1'b1) begin mismatched++; $display("FAIL to_req_hold: got %b need 1", o_req); end
    end
    cur_r = 2;
    cur_f = 2;
    rx_manual = 1'b0;
    wait_idle(60, "timeout");
    compared++;
    if (o_timeout !== 1'b1) begin mismatched++; $display("FAIL to_sticky: got %b need 1", o_timeout); end
    check_queues("timeout");
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit got;
    rx_manual = 1'b1;
    rx_manual_ack = 1'b0;
    send_beat(8'h5A, 10, ok);
    @(negedge i_clk);
    i_s_axis_tvalid = 1'b0;
    repeat (3) @(negedge i_clk);
    compared++;
    if (o_req !== 1'b1) begin mismatched++; $display("FAIL mid_pre_req: got %b need 1", o_req); end
    #2;
    i_reset_n = 1'b0;
    rx_manual_ack = 1'b1;
    #1;
    compared += 4;
    if (o_req !== 1'b0)     begin mismatched++; $display("FAIL mid_req: got %b need 0", o_req); end
    if (o_data !== '0)      begin mismatched++; $display("FAIL mid_data: got %h need 00", o_data); end
    if (o_busy !== 1'b0)    begin mismatched++; $display("FAIL mid_busy: got %b need 0", o_busy); end
    if (o_timeout !== 1'b0) begin mismatched++; $display("FAIL mid_timeout: got %b need 0", o_timeout); end
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    exp_q.delete();
    rx_q.delete();
    repeat (NUM_FFS + 1) @(negedge i_clk);
    // Ack still high from the interrupted transfer: nothing may be taken.
    i_s_axis_tvalid = 1'b1;
    i_s_axis_tdata  = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      compared++;
      if (o_s_axis_tready !== 1'b0 || o_busy !== 1'b0) begin
        mismatched++;
        $display("FAIL mid_hold@%0d: tready=%b busy=%b need 0 0", k, o_s_axis_tready, o_busy);
      end
    end
    rx_manual_ack = 1'b0;
    got = 1'b0;
    for (int k = 0; k < int'(NUM_FFS) + 4; k++) begin
      @(negedge i_clk);
      if (o_s_axis_tready) begin
        exp_q.push_back(8'hC3);
        @(posedge i_clk);
        got = 1'b1;
        break;
      end
    end
    compared++;
    if (!got) begin mismatched++; $display("FAIL mid_resume: tready=%b need 1 after ack fell", o_s_axis_tready); end
    @(negedge i_clk);
    i_s_axis_tvalid = 1'b0;
    cur_r = 2;
    cur_f = 2;
    rx_manual = 1'b0;
    wait_idle(60, "mid");
    check_queues("mid");
  endtask

  task automatic test_random();
    bit ok;
    int gap;
    stab_err = 0;
    rx_rand = 1'b1;
    cur_r = $urandom_range(1, 20);
    cur_f = $urandom_range(1, 20);
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        @(negedge i_clk);
        i_s_axis_tvalid = 1'b0;
        repeat (gap - 1) @(negedge i_clk);
      end
      send_beat(DATA_W'($urandom), 100, ok);
      if (!ok) break;
    end
    @(negedge i_clk);
    i_s_axis_tvalid = 1'b0;
    wait_idle(100, "rand");
    rx_rand = 1'b0;
    check_queues("rand");
    compared++;
    if (stab_err != 0) begin
      mismatched++;
      $display("FAIL rand_stable: o_data changed during handshake %0d times, need 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
